// File: rtl/turret_pkg.sv
// Shared types and default sweep geometry for the turret sequencer.
package turret_pkg;

   typedef enum logic [2:0] {
      StScan     = 3'd0,
      StTrack    = 3'd1,
      StSettle   = 3'd2,
      StHold     = 3'd3,
      StFire     = 3'd4,
      StCooldown = 3'd5
   } state_e;

   localparam logic [7:0] DEF_SCAN_MIN = 8'd30;
   localparam logic [7:0] DEF_SCAN_MAX = 8'd150;
   localparam logic [7:0] DEF_POS_MAX  = 8'd180;

   function automatic logic [7:0] clamp_pos(input logic [7:0] pos, input logic [7:0] ceil);
      return (pos > ceil) ? ceil : pos;
   endfunction

endpackage

// File: rtl/turret_sequencer_if.sv
// Command/status bundle between the command decoder and the turret sequencer.
interface turret_sequencer_if;

   logic       cmd_valid;
   logic [7:0] cmd_pos;
   logic       cmd_fire;
   logic       cmd_scan;
   logic       ready;
   logic [7:0] servo_pos;
   logic       trigger;
   logic [7:0] drop_cnt;
   logic [2:0] state_o;

   modport master (
      output cmd_valid, cmd_pos, cmd_fire, cmd_scan,
      input  ready, servo_pos, trigger, drop_cnt, state_o
   );

   modport slave (
      input  cmd_valid, cmd_pos, cmd_fire, cmd_scan,
      output ready, servo_pos, trigger, drop_cnt, state_o
   );

endinterface

// File: rtl/turret_step_tick.sv
// Free-running divider: one-cycle tick every STEP_DIV clocks, first one STEP_DIV cycles
// after reset release.
module turret_step_tick #(
   parameter int unsigned STEP_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/turret_sequencer.sv
// Turret servo/trigger sequencer: sweep, track a commanded target, settle, fire, cool down, hold.
module turret_sequencer
   import turret_pkg::*;
#(
   parameter int unsigned STEP_DIV        = 4,
   parameter int unsigned SETTLE_CYCLES   = 16,
   parameter int unsigned FIRE_CYCLES     = 8,
   parameter int unsigned COOLDOWN_CYCLES = 32,
   parameter int unsigned HOLD_TIMEOUT    = 64,
   parameter logic [7:0]  SCAN_MIN        = DEF_SCAN_MIN,
   parameter logic [7:0]  SCAN_MAX        = DEF_SCAN_MAX,
   parameter logic [7:0]  POS_MAX         = DEF_POS_MAX
) (
   input logic               clock,
   input logic               reset,
   turret_sequencer_if.slave bus
);

   localparam int unsigned TMAX_A = (SETTLE_CYCLES > FIRE_CYCLES) ? SETTLE_CYCLES : FIRE_CYCLES;
   localparam int unsigned TMAX_B = (COOLDOWN_CYCLES > HOLD_TIMEOUT) ? COOLDOWN_CYCLES
                                                                     : HOLD_TIMEOUT;
   localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int unsigned TW     = $clog2(TMAX + 1);

   state_e        r_state;
   logic [7:0]    r_pos;
   logic [7:0]    r_target;
   logic [7:0]    r_drop;
   logic          r_dir_up;
   logic          r_fire_req;
   logic          r_trigger;
   logic [TW-1:0] r_timer;

   logic w_tick;
   logic w_ready;
   logic w_accept;
   logic w_timer_last;

   turret_step_tick #(
      .STEP_DIV(STEP_DIV)
   ) u_step_tick (
      .clock(clock),
      .reset(reset),
      .tick (w_tick)
   );

   assign w_ready      = !(r_state == StFire || r_state == StCooldown);
   assign w_accept     = bus.cmd_valid && w_ready;
   // One down-counter serves every timed state; each phase ends on the cycle it reads 1.
   assign w_timer_last = (r_timer == TW'(1));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= StScan;
         r_pos      <= SCAN_MIN;
         r_target   <= SCAN_MIN;
         r_drop     <= '0;
         r_dir_up   <= 1'b1;
         r_fire_req <= 1'b0;
         r_trigger  <= 1'b0;
         r_timer    <= '0;
      end else begin
         if (bus.cmd_valid && !w_ready && r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
         end

         if (w_accept) begin
            r_timer <= '0;
            if (bus.cmd_scan) begin
               r_state    <= StScan;
               r_fire_req <= 1'b0;
            end else begin
               r_target   <= clamp_pos(bus.cmd_pos, POS_MAX);
               r_fire_req <= bus.cmd_fire;
               r_state    <= StTrack;
            end
         end else begin
            unique case (r_state)
               StScan: begin
                  if (w_tick) begin
                     if (r_pos > SCAN_MAX) begin
                        r_dir_up <= 1'b0;
                        r_pos    <= r_pos - 8'd1;
                     end else if (r_pos < SCAN_MIN) begin
                        r_dir_up <= 1'b1;
                        r_pos    <= r_pos + 8'd1;
                     end else if (r_dir_up) begin
                        if (r_pos >= SCAN_MAX) begin
                           r_dir_up <= 1'b0;
                           r_pos    <= r_pos - 8'd1;
                        end else begin
                           r_pos <= r_pos + 8'd1;
                        end
                     end else begin
                        if (r_pos <= SCAN_MIN) begin
                           r_dir_up <= 1'b1;
                           r_pos    <= r_pos + 8'd1;
                        end else begin
                           r_pos <= r_pos - 8'd1;
                        end
                     end
                  end
               end
               StTrack: begin
                  if (r_pos == r_target) begin
                     r_state <= StSettle;
                     r_timer <= TW'(SETTLE_CYCLES);
                  end else if (w_tick) begin
                     r_pos <= (r_target > r_pos) ? r_pos + 8'd1 : r_pos - 8'd1;
                  end
               end
               StSettle: begin
                  if (!w_timer_last) begin
                     r_timer <= r_timer - 1'b1;
                  end else if (r_fire_req) begin
                     r_state    <= StFire;
                     r_trigger  <= 1'b1;
                     r_fire_req <= 1'b0;
                     r_timer    <= TW'(FIRE_CYCLES);
                  end else begin
                     r_state <= StHold;
                     r_timer <= TW'(HOLD_TIMEOUT);
                  end
               end
               StFire: begin
                  if (w_timer_last) begin
                     r_state   <= StCooldown;
                     r_trigger <= 1'b0;
                     r_timer   <= TW'(COOLDOWN_CYCLES);
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end
               StCooldown: begin
                  if (w_timer_last) begin
                     r_state <= StHold;
                     r_timer <= TW'(HOLD_TIMEOUT);
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end
               StHold: begin
                  if (w_timer_last) begin
                     r_state <= StScan;
                     r_timer <= '0;
                  end else begin
                     r_timer <= r_timer - 1'b1;
                  end
               end
               default: begin
                  r_state   <= StScan;
                  r_trigger <= 1'b0;
                  r_timer   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.ready     = w_ready;
   assign bus.servo_pos = r_pos;
   assign bus.trigger   = r_trigger;
   assign bus.drop_cnt  = r_drop;
   assign bus.state_o   = r_state;

endmodule

// File: doc/turret_sequencer.md
TURRET_SEQUENCER -- requirements
Module: turret_sequencer

Interface
REQ-001 Parameter STEP_DIV, 4, clock cycles per servo position step (>=1).
REQ-002 Parameter SETTLE_CYCLES, 16, dwell after reaching target before fire decision (>=1).
REQ-003 Parameter FIRE_CYCLES, 8, trigger high time (>=1).
REQ-004 Parameter COOLDOWN_CYCLES, 32, trigger low lockout after firing (>=1).
REQ-005 Parameter HOLD_TIMEOUT, 64, idle cycles in HOLD before reverting to SCAN (>=1).
REQ-006 Parameter SCAN_MIN, 8'd30, lower sweep bound; SCAN_MAX, 8'd150, upper sweep bound; POS_MAX, 8'd180, target clamp ceiling.
REQ-007 clock  input  1  single clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 cmd_valid  input  1  one-cycle pulse: decoded target command present.
REQ-010 cmd_pos  input  8  target position, binary 0-255.
REQ-011 cmd_fire  input  1  fire after reaching target.
REQ-012 cmd_scan  input  1  1 = abandon target, resume sweep; overrides cmd_pos/cmd_fire.
REQ-013 ready  output  1  1 = command will be accepted this cycle.
REQ-014 servo_pos  output  8  commanded servo position.
REQ-015 trigger  output  1  fire solenoid/motor enable.
REQ-016 drop_cnt  output  8  saturating count of commands rejected while ready=0.
REQ-017 state_o  output  3  current state encoding, for debug.

Function
REQ-018 States SHALL be SCAN, TRACK, SETTLE, HOLD, FIRE, COOLDOWN.
REQ-019 step_tick SHALL pulse one cycle every STEP_DIV cycles from a free-running counter; first tick STEP_DIV cycles after reset release.
REQ-020 ready SHALL be 1 in SCAN, TRACK, SETTLE, HOLD; 0 in FIRE, COOLDOWN.
REQ-021 cmd_valid with ready=0 SHALL be discarded and increment drop_cnt, saturating at 255.
REQ-022 Accepted command, cmd_scan=1: next state SCAN, fire request cleared.
REQ-023 Accepted command, cmd_scan=0: target <= min(cmd_pos, POS_MAX), fire_req <= cmd_fire, next state TRACK; applies from TRACK/SETTLE too (retarget).
REQ-024 SCAN: on step_tick, servo_pos moves 1 in sweep direction; at SCAN_MAX direction becomes down, at SCAN_MIN up; the reversal and the step occur on the same tick (no dwell); if outside bounds, moves toward the nearer bound.
REQ-025 TRACK: on step_tick, servo_pos moves 1 toward target; when servo_pos==target (including on entry), next cycle enters SETTLE with counter loaded to SETTLE_CYCLES.
REQ-026 SETTLE: servo_pos frozen; after SETTLE_CYCLES cycles enters FIRE if fire_req else HOLD.
REQ-027 FIRE: trigger=1 for exactly FIRE_CYCLES cycles, then COOLDOWN; fire_req cleared on FIRE entry.
REQ-028 COOLDOWN: trigger=0 for exactly COOLDOWN_CYCLES cycles, then HOLD.
REQ-029 HOLD: servo_pos frozen; after HOLD_TIMEOUT cycles with no accepted command enters SCAN, sweep direction unchanged.
REQ-030 cmd_valid in the same cycle as a SETTLE/HOLD timer expiry SHALL win over the timer transition.
REQ-031 servo_pos SHALL never wrap: arithmetic 8-bit unsigned, step only when not at target/bound.
REQ-032 trigger SHALL be 1 only in FIRE (registered, glitch-free).

Reset
REQ-033 On reset: state SCAN, servo_pos=SCAN_MIN, direction up, trigger=0, drop_cnt=0, fire_req=0, target=SCAN_MIN, all timers and step counter 0.
REQ-034 Reset asserted mid-FIRE SHALL drop trigger on the same clock edge; no pending command survives reset.

Structure
REQ-035 Package turret_pkg SHALL hold the state enumeration and the SCAN_MIN/SCAN_MAX/POS_MAX defaults.
REQ-036 Sub-module turret_step_tick (parameter STEP_DIV; ports clock, reset, tick) SHALL generate step_tick; state timers SHALL share one down-counter in turret_sequencer.

Verification (bench parameters STEP_DIV=4, SETTLE=8, FIRE=5, COOLDOWN=10, HOLD_TIMEOUT=20)
REQ-037 Reset release, no commands -> servo_pos 30,31,... every 4 cycles, reaches 150, then 149; trigger stays 0.
REQ-038 cmd_pos=40, cmd_fire=1 with servo_pos=30 -> 10 steps to 40, 8 SETTLE cycles, trigger high exactly 5 cycles, ready low 15 cycles, HOLD, SCAN after 20 idle cycles.
REQ-039 cmd_valid during FIRE and COOLDOWN (3 pulses) -> drop_cnt=3, target unchanged; 256+ drops -> drop_cnt holds 255.
REQ-040 cmd_pos=200 -> servo_pos stops at 180; cmd_pos=100 then cmd_pos=60 mid-TRACK -> reverses toward 60 without SETTLE at intermediate point.
REQ-041 reset asserted 2 cycles into FIRE -> trigger=0 and servo_pos=30, state SCAN next cycle.
REQ-042 cmd_scan=1 on the HOLD-timeout cycle, and cmd_pos=70 on the SETTLE-expiry cycle -> command transition taken in both cases.
